// File: rtl/mdc_tx_pkg.sv
// mdc_tx_pkg: shared widths, mode codes, FSM states and Hamming helpers for the MDC frame transmitter
package mdc_tx_pkg;
  localparam int DATA_W = 11;
  localparam int DCODE_W = 15;
  localparam int MODE_W = 5;
  localparam int MCODE_W = 9;
  localparam int RES_W = 207;
  localparam int FRAME_N = 16;
  localparam logic [MODE_W-1:0] MODE_2X2 = 5'b00100;
  localparam logic [MODE_W-1:0] MODE_3X3 = 5'b00110;
  localparam logic [MODE_W-1:0] MODE_4X4 = 5'b10110;
  localparam int PAR_POS [4] = '{1, 2, 4, 8};
  typedef enum logic [1:0] {FILL, SEND, WAIT} state_t;
  function automatic bit is_par(input int p);
    is_par = 1'b0;
    for (int i = 0; i < 4; i++) if (PAR_POS[i] == p) is_par = 1'b1;
  endfunction
  // bit q-1 set when codeword position q belongs to parity group p
  function automatic logic [14:0] grp_mask(input int p);
    grp_mask = '0;
    for (int q = 1; q <= 15; q++) if ((q & p) != 0) grp_mask = grp_mask | (15'(1) << (q - 1));
  endfunction
endpackage

// File: rtl/mdc_hamming_enc.sv
// mdc_hamming_enc: combinational even-parity Hamming encoder, codeword position p sits at bit CW-p
module mdc_hamming_enc
  import mdc_tx_pkg::*;
#(
  parameter int DW = 11,
  parameter int CW = 15
) (
  input  logic [DW-1:0] data,
  output logic [CW-1:0] code
);
  logic [CW-1:0] dv, pv;
  for (genvar i = 0; i < CW; i++) begin : g_pos
    localparam int P = i + 1;
    if (is_par(P)) begin : g_par
      localparam logic [14:0] M = grp_mask(P);
      assign dv[i] = 1'b0;
      assign pv[i] = ^(dv & M[CW-1:0]);
    end else begin : g_dat
      // data MSB lands on the lowest non-parity position
      assign dv[i] = data[DW-P+$clog2(P+1)];
      assign pv[i] = dv[i];
    end
    assign code[CW-1-i] = pv[i];
  end
endmodule

// File: rtl/mdc_frame_tx.sv
// mdc_frame_tx: buffers and Hamming-encodes one frame, bursts it to MDC, returns the response (option MDC_TX_ERR_INJ_EN)
module mdc_frame_tx
  import mdc_tx_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int FRAME_LEN = FRAME_N
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [MODE_W-1:0]  s_mode,
  input  logic [DATA_W-1:0]  s_data,
`ifdef MDC_TX_ERR_INJ_EN
  input  logic               inj_en,
  input  logic [3:0]         inj_pos,
`endif
  output logic               in_valid,
  output logic [MCODE_W-1:0] in_mode,
  output logic [DCODE_W-1:0] in_data,
  input  logic               out_valid,
  input  logic [RES_W-1:0]   out_data,
  output logic               res_valid,
  output logic [RES_W-1:0]   res_data,
  output logic               res_timeout,
  output logic               proto_err
);
  state_t st;
  logic [3:0] idx;
  logic [15:0] cnt;
  logic [MCODE_W-1:0] mode_q, enc_m;
  logic [DCODE_W-1:0] enc_d, enc_w;
  logic [DCODE_W-1:0] mem [FRAME_LEN];
  logic acc;
  assign s_ready = st == FILL;
  assign acc = s_valid && s_ready;
  mdc_hamming_enc #(.DW(DATA_W), .CW(DCODE_W)) u_enc_d (.data(s_data), .code(enc_d));
  mdc_hamming_enc #(.DW(MODE_W), .CW(MCODE_W)) u_enc_m (.data(s_mode), .code(enc_m));
`ifdef MDC_TX_ERR_INJ_EN
  logic inj_en_q, flip_en;
  logic [3:0] inj_pos_q, flip_pos;
  // element 0 uses the live controls, later elements the values captured with it
  assign flip_en = idx == 4'd0 ? inj_en : inj_en_q;
  assign flip_pos = idx == 4'd0 ? inj_pos : inj_pos_q;
  assign enc_w = enc_d ^ ((flip_en && flip_pos != 4'd0) ? (15'h4000 >> (flip_pos - 4'd1)) : '0);
  always_ff @(posedge clk)
    if (!rst_n) begin
      inj_en_q <= 1'b0;
      inj_pos_q <= '0;
    end else if (acc && idx == 4'd0) begin
      inj_en_q <= inj_en;
      inj_pos_q <= inj_pos;
    end
`else
  assign enc_w = enc_d;
`endif
  always_ff @(posedge clk)
    if (acc) mem[idx] <= enc_w;
  always_ff @(posedge clk)
    if (!rst_n) begin
      st <= FILL;
      idx <= '0;
      cnt <= '0;
      mode_q <= '0;
      in_valid <= 1'b0;
      in_mode <= '0;
      in_data <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_timeout <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (out_valid && st != WAIT) proto_err <= 1'b1;
      case (st)
        FILL: if (acc) begin
          if (idx == 4'd0) mode_q <= enc_m;
          idx <= idx + 4'd1;
          if (idx == 4'(FRAME_LEN - 1)) begin
            // idx doubles as the burst read pointer, one ahead of the presented word
            st <= SEND;
            idx <= 4'd1;
            in_valid <= 1'b1;
            in_data <= mem[0];
            in_mode <= mode_q;
          end
        end
        SEND: begin
          in_mode <= '0;
          if (idx == 4'd0) begin
            st <= WAIT;
            in_valid <= 1'b0;
            in_data <= '0;
            cnt <= 16'd1;
          end else begin
            in_data <= mem[idx];
            idx <= idx + 4'd1;
          end
        end
        WAIT: if (out_valid || cnt == 16'(TIMEOUT)) begin
          st <= FILL;
          idx <= '0;
          res_valid <= 1'b1;
          res_timeout <= !out_valid;
          res_data <= out_valid ? out_data : '0;
        end else cnt <= cnt + 16'd1;
        default: st <= FILL;
      endcase
    end
endmodule
